rate_match_timer: RTL and testbench



---
 rtl/rate_match_pkg.sv | 21 ++
 rtl/rate_match_sat_cnt.sv | 37 +++
 rtl/rate_match_timer.sv | 133 +++++++++++++
 tb/tb_rate_match_timer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rate_match_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rate_match_pkg
//  Description : Shared types and constants for the rate-matching timer.
//                Holds the state encoding and the run-mode constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package rate_match_pkg;

  // Controller state: idle waiting for start, or counting a run.
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  // Run mode, captured when a start is accepted.
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage : rate_match_pkg
`default_nettype wire

// File: rtl/rate_match_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : rate_match_sat_cnt
//  Description : W-bit saturating up-counter with synchronous clear.
//                Clear has priority over increment; the counter sticks at
//                all-ones once it gets there.
//  Ports       : clk    - clock
//                rst    - synchronous active-high reset
//                clr_i  - clear to zero
//                inc_i  - increment by one (saturating)
//                cnt_o  - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module rate_match_sat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule : rate_match_sat_cnt
`default_nettype wire

// File: rtl/rate_match_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rate_match_timer
//  Description : Programmable rate-matching timer. Emits a one-cycle
//                completion strobe every TC+1 enabled cycles, in periodic
//                or one-shot mode, with a sticky pending flag cleared by
//                ack and a saturating count of events lost while pending.
//  Ports       : clk            - clock
//                rst            - synchronous active-high reset
//                en_i           - count enable (0 freezes the count)
//                start_i        - begin a run (accepted in IDLE only)
//                abort_i        - end the run, back to IDLE, no event
//                mode_i         - 0 periodic / 1 one-shot, captured on start
//                tc_load_i      - load tc_in_i as terminal count (IDLE only)
//                tc_in_i        - new terminal count
//                ack_i          - consumer acknowledge of pending event
//                done_pulse_o   - one-cycle completion strobe
//                done_pending_o - sticky event flag
//                busy_o         - high while counting
//                count_o        - current count value
//                miss_cnt_o     - events lost while pending (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module rate_match_timer
  import rate_match_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int DEFAULT_TC = 88,
  parameter int MISS_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              mode_i,
  input  logic              tc_load_i,
  input  logic [CNT_W-1:0]  tc_in_i,
  input  logic              ack_i,
  output logic              done_pulse_o,
  output logic              done_pending_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [MISS_W-1:0] miss_cnt_o
);

  state_e             state_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   tc_q;
  logic               mode_q;
  logic               done_pulse_q;
  logic               done_pending_q;

  logic               done_pulse_d;
  logic               start_acc;
  logic               miss_inc;

  // Terminal event: abort suppresses it even when the count matches.
  assign done_pulse_d = (state_q == COUNT) && en_i && !abort_i && (count_q == tc_q);
  assign start_acc    = (state_q == IDLE) && start_i && !abort_i;
  // An event landing on an un-acked pending flag is lost; an ack in the
  // same cycle consumes the old event, so nothing is lost then.
  assign miss_inc     = done_pulse_d && done_pending_q && !ack_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      count_q        <= '0;
      tc_q           <= CNT_W'(DEFAULT_TC);
      mode_q         <= MODE_PERIODIC;
      done_pulse_q   <= 1'b0;
      done_pending_q <= 1'b0;
    end else begin
      done_pulse_q <= done_pulse_d;

      // New event beats a coincident ack.
      if (done_pulse_d) begin
        done_pending_q <= 1'b1;
      end else if (ack_i) begin
        done_pending_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          count_q <= '0;
          if (tc_load_i) begin
            tc_q <= tc_in_i;
          end
          if (start_acc) begin
            state_q <= COUNT;
            mode_q  <= mode_i;
          end
        end
        COUNT: begin
          if (abort_i) begin
            state_q <= IDLE;
            count_q <= '0;
          end else if (en_i) begin
            if (count_q == tc_q) begin
              count_q <= '0;
              if (mode_q == MODE_ONESHOT) begin
                state_q <= IDLE;
              end
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  rate_match_sat_cnt #(
    .W (MISS_W)
  ) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_acc),
    .inc_i (miss_inc),
    .cnt_o (miss_cnt_o)
  );

  assign done_pulse_o   = done_pulse_q;
  assign done_pending_o = done_pending_q;
  assign busy_o         = (state_q == COUNT);
  assign count_o        = count_q;

endmodule : rate_match_timer
`default_nettype wire

// File: tb/tb_rate_match_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rate_match_timer
//  Description : Directed self-checking bench for rate_match_timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rate_match_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, start, abort, mode, tc_load, ack;
  logic [7:0] tc_in;
  logic       done_pulse, done_pending, busy;
  logic [7:0] count;
  logic [3:0] miss_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rate_match_timer #(
    .CNT_W      (8),
    .DEFAULT_TC (88),
    .MISS_W     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en_i           (en),
    .start_i        (start),
    .abort_i        (abort),
    .mode_i         (mode),
    .tc_load_i      (tc_load),
    .tc_in_i        (tc_in),
    .ack_i          (ack),
    .done_pulse_o   (done_pulse),
    .done_pending_o (done_pending),
    .busy_o         (busy),
    .count_o        (count),
    .miss_cnt_o     (miss_cnt)
  );

  // Advance one clock edge, then settle before sampling / driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    tc_load = 1'b0; tc_in = '0; ack = 1'b0;
    step(); step();
    rst = 1'b0;
    tests++; if (count !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done_pulse !== 1'b0) begin fails++; $display("FAIL reset_pulse: got %b want 0", done_pulse); end
    tests++; if (done_pending !== 1'b0) begin fails++; $display("FAIL reset_pending: got %b want 0", done_pending); end
    tests++; if (miss_cnt !== 4'd0) begin fails++; $display("FAIL reset_miss: got %0d want 0", miss_cnt); end
  endtask

  // Default tc=88, periodic: events 89 cycles after start, then every 89.
  task automatic test_periodic_default();
    start = 1'b1; mode = 1'b0; en = 1'b1;
    step();
    start = 1'b0;
    tests++; if (busy !== 1'b1 || count !== 8'd0) begin fails++; $display("FAIL per_start: busy=%b count=%0d want busy=1 count=0", busy, count); end
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 1; k <= 88; k++) begin
        step();
        tests++; if (count !== 8'(k) || done_pulse !== 1'b0 || busy !== 1'b1) begin
          fails++; $display("FAIL per_count rep%0d k%0d: count=%0d pulse=%b busy=%b want %0d/0/1", rep, k, count, done_pulse, busy, k);
        end
      end
      step();
      tests++; if (done_pulse !== 1'b1 || count !== 8'd0 || busy !== 1'b1) begin
        fails++; $display("FAIL per_event rep%0d: pulse=%b count=%0d busy=%b want 1/0/1", rep, done_pulse, count, busy);
      end
    end
    // Second event landed while pending -> one miss.
    tests++; if (miss_cnt !== 4'd1) begin fails++; $display("FAIL per_miss: got %0d want 1", miss_cnt); end
    abort = 1'b1; ack = 1'b1;
    step();
    abort = 1'b0; ack = 1'b0;
    tests++; if (busy !== 1'b0 || done_pending !== 1'b0) begin fails++; $display("FAIL per_abort: busy=%b pend=%b want 0/0", busy, done_pending); end
  endtask

  // tc_load and start together: one-shot run uses the new tc=3.
  task automatic test_oneshot();
    tc_load = 1'b1; tc_in = 8'd3; start = 1'b1; mode = 1'b1; en = 1'b1;
    step();
    tc_load = 1'b0; start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      tests++; if (count !== 8'(k) || done_pulse !== 1'b0) begin fails++; $display("FAIL os_count k%0d: count=%0d pulse=%b", k, count, done_pulse); end
    end
    step();
    tests++; if (done_pulse !== 1'b1 || busy !== 1'b0 || count !== 8'd0) begin
      fails++; $display("FAIL os_event: pulse=%b busy=%b count=%0d want 1/0/0", done_pulse, busy, count);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      tests++; if (done_pulse !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin
        fails++; $display("FAIL os_quiet k%0d: pulse=%b busy=%b count=%0d", k, done_pulse, busy, count);
      end
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  // tc=3 periodic with en toggling: count moves only on enabled cycles.
  task automatic test_en_toggle();
    int exp_cnt;
    int last_ev;
    logic exp_pulse;
    start = 1'b1; mode = 1'b0; en = 1'b1;
    step();
    start = 1'b0;
    exp_cnt = 0; last_ev = -1;
    for (int i = 0; i < 32; i++) begin
      en = (i % 2 == 0);
      exp_pulse = 1'b0;
      if (en) begin
        if (exp_cnt == 3) begin exp_cnt = 0; exp_pulse = 1'b1; end
        else exp_cnt++;
      end
      step();
      tests++; if (count !== 8'(exp_cnt) || done_pulse !== exp_pulse) begin
        fails++; $display("FAIL en_tog i%0d: count=%0d pulse=%b want %0d/%b", i, count, done_pulse, exp_cnt, exp_pulse);
      end
      if (done_pulse === 1'b1) begin
        if (last_ev >= 0) begin
          tests++; if (i - last_ev != 8) begin fails++; $display("FAIL en_spacing: got %0d want 8", i - last_ev); end
        end
        last_ev = i;
      end
    end
    en = 1'b1; abort = 1'b1; ack = 1'b1;
    step();
    abort = 1'b0; ack = 1'b0;
  endtask

  // tc=2 periodic, ack withheld except on event 3: miss_cnt saturates at 15.
  task automatic test_miss_sat();
    int exp_miss;
    tc_load = 1'b1; tc_in = 8'd2; start = 1'b1; mode = 1'b0; en = 1'b1;
    step();
    tc_load = 1'b0; start = 1'b0;
    tests++; if (miss_cnt !== 4'd0) begin fails++; $display("FAIL miss_start_clr: got %0d want 0", miss_cnt); end
    for (int n = 1; n <= 20; n++) begin
      step(); step();
      ack = (n == 3);
      step();
      ack = 1'b0;
      if (n < 3) exp_miss = n - 1;
      else if (n == 3) exp_miss = 1;
      else exp_miss = (n - 2 > 15) ? 15 : n - 2;
      tests++; if (done_pulse !== 1'b1 || done_pending !== 1'b1 || miss_cnt !== 4'(exp_miss)) begin
        fails++; $display("FAIL miss ev%0d: pulse=%b pend=%b miss=%0d want 1/1/%0d", n, done_pulse, done_pending, miss_cnt, exp_miss);
      end
    end
    abort = 1'b1; ack = 1'b1;
    step();
    abort = 1'b0; ack = 1'b0;
  endtask

  // Abort on the terminal cycle, and start/tc_load ignored while counting.
  task automatic test_abort_ignore();
    start = 1'b1; mode = 1'b0; en = 1'b1;
    step();
    start = 1'b1; tc_load = 1'b1; tc_in = 8'd7;
    step();
    start = 1'b0; tc_load = 1'b0;
    tests++; if (count !== 8'd1 || busy !== 1'b1) begin fails++; $display("FAIL start_in_count: count=%0d busy=%b want 1/1", count, busy); end
    step();
    tests++; if (count !== 8'd2) begin fails++; $display("FAIL pre_abort: count=%0d want 2", count); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests++; if (done_pulse !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin
      fails++; $display("FAIL abort_tc: pulse=%b busy=%b count=%0d want 0/0/0", done_pulse, busy, count);
    end
    // tc must still be 2: one-shot event 3 cycles after start.
    start = 1'b1; mode = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    tests++; if (done_pulse !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL tc_kept: pulse=%b busy=%b want 1/0", done_pulse, busy); end
  endtask

  // Reset at count=40 of a tc=88 run (pending left set from previous test).
  task automatic test_reset_mid_run();
    tc_load = 1'b1; tc_in = 8'd88; start = 1'b1; mode = 1'b0; en = 1'b1;
    step();
    tc_load = 1'b0; start = 1'b0;
    for (int k = 0; k < 40; k++) step();
    tests++; if (count !== 8'd40 || done_pending !== 1'b1) begin fails++; $display("FAIL mid_pre: count=%0d pend=%b want 40/1", count, done_pending); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (count !== 8'd0 || busy !== 1'b0 || done_pending !== 1'b0 || miss_cnt !== 4'd0 || done_pulse !== 1'b0) begin
      fails++; $display("FAIL mid_reset: count=%0d busy=%b pend=%b miss=%0d pulse=%b want 0s", count, busy, done_pending, miss_cnt, done_pulse);
    end
    for (int k = 0; k < 60; k++) begin
      step();
      tests++; if (done_pulse !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_quiet k%0d: pulse=%b busy=%b", k, done_pulse, busy); end
    end
    // tc restored to 88 by reset: one-shot event exactly 89 cycles after start.
    start = 1'b1; mode = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 88; k++) begin
      step();
      tests++; if (done_pulse !== 1'b0) begin fails++; $display("FAIL mid_tc_early k%0d: pulse=%b want 0", k, done_pulse); end
    end
    step();
    tests++; if (done_pulse !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL mid_tc_event: pulse=%b busy=%b want 1/0", done_pulse, busy); end
  endtask

  initial begin
    test_reset();
    test_periodic_default();
    test_oneshot();
    test_en_toggle();
    test_miss_sat();
    test_abort_ignore();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_rate_match_timer
`default_nettype wire
